hawk_tbl_wr_engine: RTL and testbench

Parametrised AXI write engine for HACD table maintenance (ATT, list tables, future tables). It accepts commands from the hawk control unit or the page managers and executes them on the hawk AXI master write channels. Two operations are supported:
- FILL: write a repeated line pattern over N consecutive cache lines (table initialisation).
- WRITE: one strobed line write (entry/pointer update).
Unlike the previous single-beat manager, it decouples AW and W, keeps up to MAX_OUTSTANDING writes in flight, and reports completion only once every B response of a command has returned.

---
 rtl/hawk_tbl_wr_engine.sv | 173 +++++++++++++++++
 tb/tb_hawk_tbl_wr_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_tbl_wr_engine.sv
// HACD table write engine: FILL (repeated line over N lines) and strobed single-line WRITE
// on decoupled AXI AW/W channels, with bounded outstanding writes and B-response tracking.
module hawk_tbl_wr_engine #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned LEN_W           = 20,
  localparam int unsigned STRB_W         = DATA_W / 8,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [STRB_W-1:0] cmd_strb_i,
  output logic              cmd_done_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i,
  output logic [CNT_W-1:0]  outstanding_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(DATA_W / 8);
  localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [STRB_W-1:0]  strb_q, strb_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic aw_hs_s, w_hs_s, beat_done_s, b_dec_s, err_new_s;

  // Next-state, beat sequencing, outstanding counter and sticky error.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    strb_d        = strb_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    done_d        = 1'b0;

    aw_hs_s     = awvalid_q & awready_i;
    w_hs_s      = wvalid_q & wready_i;
    awvalid_d   = awvalid_q & ~aw_hs_s;
    wvalid_d    = wvalid_q & ~w_hs_s;
    // A beat retires on the cycle its later handshake lands.
    beat_done_s = (awvalid_q | wvalid_q) & ~awvalid_d & ~wvalid_d;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d      = cmd_addr_i;
          data_d      = cmd_data_i;
          strb_d      = cmd_op_i ? cmd_strb_i : {STRB_W{1'b1}};
          remaining_d = cmd_op_i ? LEN_W'(1) : cmd_len_i;
          if (!cmd_op_i && (cmd_len_i == LEN_W'(0))) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (beat_done_s) begin
          remaining_d = remaining_q - LEN_W'(1);
          addr_d      = addr_q + ADDR_STRIDE;
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (!awvalid_q && !wvalid_q && (remaining_q != LEN_W'(0))
                     && (outstanding_q < MAX_CNT)) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == CNT_W'(0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    b_dec_s = bvalid_i & (outstanding_q != CNT_W'(0));
    case ({aw_hs_s, b_dec_s})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // A stray B with nothing in flight is an error as well as a bad response.
    err_new_s = bvalid_i & ((bresp_i != 2'b00) | (outstanding_q == CNT_W'(0)));
    err_d     = err_new_s | (err_q & ~err_clr_i);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      remaining_q   <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      strb_q        <= strb_d;
      remaining_q   <= remaining_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign cmd_done_o    = done_q;
  assign err_o         = err_q;
  assign awvalid_o     = awvalid_q;
  assign awaddr_o      = addr_q;
  assign wvalid_o      = wvalid_q;
  assign wdata_o       = data_q;
  assign wstrb_o       = strb_q;
  assign bready_o      = 1'b1;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_hawk_tbl_wr_engine.sv
// Randomised bench for hawk_tbl_wr_engine: an AXI slave model plus a per-command
// list of expected lines, with per-cycle checks of counter, error and channel stability.
module tb_hawk_tbl_wr_engine;
  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int SW   = DW / 8;
  localparam int MAXO = 2;
  localparam int LW   = 20;
  localparam int CW   = $clog2(MAXO) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i, cmd_ready_o, cmd_op_i, cmd_done_o, busy_o, err_o, err_clr_i;
  logic [AW-1:0] cmd_addr_i, awaddr_o;
  logic [LW-1:0] cmd_len_i;
  logic [DW-1:0] cmd_data_i, wdata_o;
  logic [SW-1:0] cmd_strb_i, wstrb_o;
  logic          awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [1:0]    bresp_i;
  logic [CW-1:0] outstanding_o;

  hawk_tbl_wr_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i), .cmd_done_o(cmd_done_o),
    .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  longint        cyc = 0;
  int            model_out;
  bit            model_err;
  logic [AW-1:0] aw_log[$], e_addr[$];
  logic [DW-1:0] wd_log[$], e_data[$];
  logic [SW-1:0] ws_log[$], e_strb[$];
  longint        b_rel[$];
  // slave knobs
  int  aw_pct = 100, w_pct = 100, b_delay = 1, b_allow = 0, w_block = 0;
  int  bad_b_idx = 0, b_num = 0, sim_events = 0, done_cnt = 0, w_stalls = 0;
  bit  b_hold = 1'b0, aw_low = 1'b0, w_block_mode = 1'b0, spur_b = 1'b0, err_clr_req = 1'b0;
  bit  prev_done, prev_awv, prev_wv, prev_awhs, prev_whs;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;

  task automatic model_clear();
    aw_log.delete(); wd_log.delete(); ws_log.delete(); b_rel.delete();
    e_addr.delete(); e_data.delete(); e_strb.delete();
    model_out = 0; model_err = 1'b0; w_block = 0;
    prev_done = 1'b0; prev_awv = 1'b0; prev_wv = 1'b0; prev_awhs = 1'b0; prev_whs = 1'b0;
  endtask

  // One cycle: check outputs at the negedge, drive slave inputs, update the model for the next posedge.
  task automatic step();
    bit aw_hs, w_hs, b_go;
    int out_old;
    @(negedge clk_i);
    chk("outstanding", outstanding_o, model_out);
    chk("err", err_o, model_err);
    if (awvalid_o) chk("aw_below_max", model_out < MAXO, 1'b1);
    if (prev_awv && !prev_awhs) begin
      chk("aw_hold", awvalid_o, 1'b1);
      chk("awaddr_hold", awaddr_o, prev_addr);
    end
    if (prev_wv && !prev_whs) begin
      chk("w_hold", wvalid_o, 1'b1);
      chk("wdata_hold", wdata_o, prev_data);
      chk("wstrb_hold", wstrb_o, prev_strb);
      chk("awaddr_w_pending", awaddr_o, prev_addr);
    end
    if (prev_awv && prev_awhs && prev_wv && !prev_whs) chk("aw_drop", awvalid_o, 1'b0);
    if (prev_wv && prev_whs && prev_awv && !prev_awhs) chk("w_drop", wvalid_o, 1'b0);
    if (prev_done) chk("done_one_cycle", cmd_done_o, 1'b0);
    if (cmd_done_o) begin
      done_cnt++;
      chk("done_drained", model_out, 0);
      chk("done_ready", cmd_ready_o, 1'b1);
    end
    prev_done = cmd_done_o;

    if (!rst_ni) begin
      awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00; err_clr_i = 1'b0;
      model_clear();
    end else begin
      awready_i = !aw_low && ($urandom_range(99) < aw_pct);
      wready_i  = (w_block == 0) && !(w_block_mode && awvalid_o) && ($urandom_range(99) < w_pct);
      err_clr_i = err_clr_req;
      err_clr_req = 1'b0;
      b_go = 1'b0;
      bresp_i = 2'b00;
      if (b_rel.size() > 0 && b_rel[0] <= cyc && (!b_hold || b_allow > 0)) begin
        b_go = 1'b1;
        b_num++;
        bresp_i = (b_num == bad_b_idx) ? 2'b10 : 2'b00;
        if (b_hold) b_allow--;
        void'(b_rel.pop_front());
      end else if (spur_b) begin
        b_go = 1'b1;
        spur_b = 1'b0;
      end
      bvalid_i = b_go;

      aw_hs = awvalid_o && awready_i;
      w_hs  = wvalid_o && wready_i;
      out_old = model_out;
      if (wvalid_o && !wready_i) w_stalls++;
      if (w_block > 0) w_block--;
      if (aw_hs) begin
        aw_log.push_back(awaddr_o);
        b_rel.push_back(cyc + 1 + b_delay);
        model_out++;
        if (w_block_mode) w_block = 5;
      end
      if (w_hs) begin
        wd_log.push_back(wdata_o);
        ws_log.push_back(wstrb_o);
      end
      if (b_go && out_old > 0) model_out--;
      if (b_go && out_old > 0 && aw_hs) sim_events++;
      model_err = (b_go && (bresp_i != 2'b00 || out_old == 0)) || (model_err && !err_clr_i);
      prev_awv = awvalid_o; prev_wv = wvalid_o; prev_awhs = aw_hs; prev_whs = w_hs;
      prev_addr = awaddr_o; prev_data = wdata_o; prev_strb = wstrb_o;
    end
    cyc++;
  endtask

  task automatic start_cmd(input bit op, input logic [AW-1:0] addr, input int len,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb, output int waited);
    logic [AW-1:0] a;
    waited = 0;
    while (!cmd_ready_o && waited < 3000) begin
      step();
      waited++;
    end
    chk("ready_wait", cmd_ready_o, 1'b1);
    a = addr;
    for (int i = 0; i < (op ? 1 : len); i++) begin
      e_addr.push_back(a);
      e_data.push_back(data);
      e_strb.push_back(op ? strb : {SW{1'b1}});
      a = a + 64'(SW);
    end
    done_cnt = 0;
    b_num = 0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_len_i = LW'(len);
    cmd_data_i = data; cmd_strb_i = strb;
    step();
    cmd_valid_i = 1'b0;
    chk("accepted_busy", busy_o, 1'b1);
  endtask

  task automatic finish_cmd(output int n);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    chk("done_seen", done_cnt, 1);
    chk("aw_count", aw_log.size(), e_addr.size());
    chk("w_count", wd_log.size(), e_data.size());
    for (int i = 0; i < e_addr.size() && i < aw_log.size(); i++) chk("aw_addr", aw_log[i], e_addr[i]);
    for (int i = 0; i < e_data.size() && i < wd_log.size(); i++) begin
      chk("w_data", wd_log[i], e_data[i]);
      chk("w_strb", ws_log[i], e_strb[i]);
    end
    aw_log.delete(); wd_log.delete(); ws_log.delete();
    e_addr.delete(); e_data.delete(); e_strb.delete();
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    int w, n, s0;
    logic [AW-1:0] ra;
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    cmd_data_i = '0; cmd_strb_i = '0; err_clr_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    model_clear();
    repeat (3) step();
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_done", cmd_done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_awvalid", awvalid_o, 1'b0);
    chk("rst_wvalid", wvalid_o, 1'b0);
    chk("rst_awaddr", awaddr_o, 64'h0);
    chk("rst_wdata", wdata_o, 512'h0);
    chk("rst_wstrb", wstrb_o, 64'h0);
    rst_ni = 1'b1;
    step();
    chk("bready_const", bready_o, 1'b1);

    // FILL over four lines with B two cycles after each AW
    start_cmd(1'b0, 64'h1000, 4, {64{8'hA5}}, 64'h0, w);
    finish_cmd(n);
    chk("fill_drained", outstanding_o, 0);

    // single strobed WRITE, then a command accepted in the done cycle
    start_cmd(1'b1, 64'h2040, 0, rnd_line(), 64'h000F0000_00000000, w);
    finish_cmd(n);
    start_cmd(1'b1, 64'h2080, 0, rnd_line(), 64'hFFFF_0000_0000_0001, w);
    chk("accept_on_done", w, 0);
    finish_cmd(n);

    // W held off five cycles after each AW
    w_block_mode = 1'b1;
    w_stalls = 0;
    start_cmd(1'b0, 64'h3000, 3, rnd_line(), 64'h0, w);
    finish_cmd(n);
    chk("w_backpressure_seen", w_stalls >= 15, 1'b1);
    w_block_mode = 1'b0;

    // outstanding limit with B withheld
    b_hold = 1'b1; b_allow = 0; b_delay = 0;
    start_cmd(1'b0, 64'h4000, 5, rnd_line(), 64'h0, w);
    repeat (20) step();
    chk("max_aw_count", aw_log.size(), 2);
    chk("max_outstanding", outstanding_o, 2);
    b_allow = 1;
    repeat (10) step();
    chk("one_more_aw", aw_log.size(), 3);
    aw_low = 1'b1; b_allow = 1;
    repeat (6) step();
    chk("stalled_aw", awvalid_o, 1'b1);
    s0 = sim_events;
    aw_low = 1'b0; b_allow = 1;
    step();
    chk("aw_b_same_cycle", sim_events, s0 + 1);
    b_hold = 1'b0;
    finish_cmd(n);

    // error response on the second B, clear, stray B, clear racing a new error
    b_delay = 1; bad_b_idx = 2;
    start_cmd(1'b0, 64'h5000, 3, rnd_line(), 64'h0, w);
    finish_cmd(n);
    bad_b_idx = 0;
    chk("err_after_bresp", err_o, 1'b1);
    err_clr_req = 1'b1;
    step(); step();
    chk("err_cleared", err_o, 1'b0);
    spur_b = 1'b1;
    step(); step();
    chk("spur_err", err_o, 1'b1);
    chk("spur_outstanding", outstanding_o, 0);
    err_clr_req = 1'b1; spur_b = 1'b1;
    step(); step();
    chk("new_err_beats_clr", err_o, 1'b1);
    err_clr_req = 1'b1;
    step();

    // zero-length FILL
    start_cmd(1'b0, 64'h6000, 0, rnd_line(), 64'h0, w);
    finish_cmd(n);
    chk("len0_latency", n, 1);

    // reset mid-FILL
    b_delay = 3;
    start_cmd(1'b0, 64'h7000, 8, rnd_line(), 64'h0, w);
    repeat (5) step();
    rst_ni = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_awvalid", awvalid_o, 1'b0);
    chk("mid_rst_wvalid", wvalid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_out", outstanding_o, 0);
    chk("mid_rst_awaddr", awaddr_o, 64'h0);
    chk("mid_rst_wdata", wdata_o, 512'h0);
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    chk("post_rst_ready", cmd_ready_o, 1'b1);

    // address wrap at the top of the address space
    start_cmd(1'b0, 64'hFFFF_FFFF_FFFF_FF80, 4, rnd_line(), 64'h0, w);
    finish_cmd(n);

    // randomised commands and slave behaviour
    for (int k = 0; k < 16; k++) begin
      aw_pct  = $urandom_range(100, 30);
      w_pct   = $urandom_range(100, 30);
      b_delay = $urandom_range(4, 0);
      ra = {$urandom, $urandom};
      ra[5:0] = 6'h0;
      start_cmd(1'($urandom_range(1, 0)), ra, $urandom_range(6, 0), rnd_line(),
                {$urandom, $urandom}, w);
      finish_cmd(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
